reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Issue-stage hazard controller for the integer register file (REG_NUM entries, one write port, two combinational read ports).
- Tracks which architectural registers have an in-flight producer, and stalls issue on RAW and WAW hazards.
- Releases a register when its producer's tagged writeback is committed on the register-file write port.
- Sits between decode/issue and the register file; the writeback stage drives its clear port in parallel with the register file's write port.

Parameters:
- REG_NUM, 32, number of architectural registers.
- REG_WIDTH, 5, register address width (clog2 of REG_NUM).
- TAG_WIDTH, 2, producer tag width; identifies the execution unit or instance that will write the register.
- CNT_WIDTH, 16, stall cycle counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- iss_valid  in  1  issue slot holds a valid instruction.
- iss_ready  out  1  instruction may issue this cycle (hazard-free and no flush).
- iss_r1_en  in  1  source 1 is read.
- iss_r1_addr  in  REG_WIDTH  source 1 register.
- iss_r2_en  in  1  source 2 is read.
- iss_r2_addr  in  REG_WIDTH  source 2 register.
- iss_rd_en  in  1  instruction writes a destination.
- iss_rd_addr  in  REG_WIDTH  destination register.
- iss_tag  in  TAG_WIDTH  producer tag recorded for the destination.
- wb_en  in  1  writeback commits this cycle; same timing as the register-file write enable.
- wb_addr  in  REG_WIDTH  writeback register.
- wb_tag  in  TAG_WIDTH  tag of the committing producer.
- flush  in  1  pipeline flush: discard all in-flight producers.
- busy_vec  out  REG_NUM  registered per-register busy bits; bit 0 is always 0.
- stall_cnt  out  CNT_WIDTH  saturating count of stalled cycles.

Behaviour:
- Reset (rst=0, async):
  - busy_vec=0, all stored tags=0, stall_cnt=0.
  - iss_ready then evaluates to !flush, since no hazards exist.
- State: busy[REG_NUM] bits and tag[REG_NUM][TAG_WIDTH]. Register 0 is never set busy and never raises a hazard.
- Hazard terms (combinational from current state and issue inputs):
  - raw1 = iss_r1_en & iss_r1_addr!=0 & busy[iss_r1_addr].
  - raw2 = the same for r2.
  - waw = iss_rd_en & iss_rd_addr!=0 & busy[iss_rd_addr].
- iss_ready = !(raw1|raw2|waw) & !flush.
  - iss_ready is independent of iss_valid, so issue may gate on it without a loop.
- No same-cycle bypass: the register file writes at the clock edge, so a source whose writeback occurs in cycle N still stalls in cycle N and becomes ready in cycle N+1.
- Issue fire = iss_valid & iss_ready. If iss_rd_en & iss_rd_addr!=0, then at the next edge busy[rd]<=1 and tag[rd]<=iss_tag.
- Clear: if wb_en & wb_addr!=0 & busy[wb_addr] & tag[wb_addr]==wb_tag, then busy[wb_addr]<=0 at the next edge.
  - A tag mismatch, or a writeback to a non-busy register, is ignored.
- Simultaneous set and clear of the same register cannot happen, because waw blocks issue to a busy register. The implementation still gives set priority.
- Set and clear on different registers in the same cycle both take effect.
- flush=1:
  - iss_ready=0 that cycle, so no set occurs.
  - At the next edge all busy bits clear and tags are left unchanged.
  - Writeback in the same cycle as flush is irrelevant, since all bits clear anyway.
- stall_cnt increments by 1 each cycle with iss_valid & !iss_ready, saturates at all-ones, and clears only on reset.
- Reset mid-operation discards all pending state immediately. A late writeback after reset is ignored because the target is no longer busy.

Test Plan:
- Reset, then issue rd=5 tag=1 → busy_vec=0x20 next cycle. Next instruction reads r1=5 → iss_ready=0.
- With busy[5] tag=1, assert wb_en addr=5 tag=1 in cycle N:
  - iss_ready stays 0 in N.
  - busy_vec=0 and iss_ready=1 in N+1.
  - stall_cnt equals the number of stalled cycles.
- With busy[5] tag=1, writeback addr=5 tag=2 → busy stays set and iss_ready stays 0.
- Issue rd=0 → busy_vec stays 0. Source r2=0 never stalls.
- WAW: busy[7], issue with rd=7 and no sources → iss_ready=0 until the matching writeback clears it.
- Set busy on registers 3, 9 and 31, then flush=1 for one cycle:
  - iss_ready=0 during the flush cycle.
  - busy_vec=0 the next cycle.
  - Assert rst low mid-stall → stall_cnt=0 and busy_vec=0 immediately (asynchronously).

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight producers per architectural register and stalls issue on RAW/WAW hazards.
// Latency: iss_ready is combinational; busy bits update one cycle after issue/writeback/flush.
// Backpressure: iss_ready drops while any hazard or flush is present; it is independent of iss_valid.
module reg_scoreboard #(
  parameter int REG_NUM   = 32,
  parameter int REG_WIDTH = 5,
  parameter int TAG_WIDTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic                 iss_r1_en,
  input  logic [REG_WIDTH-1:0] iss_r1_addr,
  input  logic                 iss_r2_en,
  input  logic [REG_WIDTH-1:0] iss_r2_addr,
  input  logic                 iss_rd_en,
  input  logic [REG_WIDTH-1:0] iss_rd_addr,
  input  logic [TAG_WIDTH-1:0] iss_tag,
  input  logic                 wb_en,
  input  logic [REG_WIDTH-1:0] wb_addr,
  input  logic [TAG_WIDTH-1:0] wb_tag,
  input  logic                 flush,
  output logic [REG_NUM-1:0]   busy_vec,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  logic [REG_NUM-1:0]   busy_q;
  logic [REG_NUM-1:0]   busy_d;
  logic [TAG_WIDTH-1:0] tag_q [REG_NUM];

  logic raw1;
  logic raw2;
  logic waw;
  logic set_en;
  logic clr_en;

  // Hazards look only at registered state: a writeback landing this cycle is not bypassed.
  assign raw1 = iss_r1_en && (iss_r1_addr != '0) && busy_q[iss_r1_addr];
  assign raw2 = iss_r2_en && (iss_r2_addr != '0) && busy_q[iss_r2_addr];
  assign waw  = iss_rd_en && (iss_rd_addr != '0) && busy_q[iss_rd_addr];

  assign iss_ready = !(raw1 || raw2 || waw) && !flush;

  assign set_en = iss_valid && iss_ready && iss_rd_en && (iss_rd_addr != '0);
  assign clr_en = wb_en && (wb_addr != '0) && busy_q[wb_addr] && (tag_q[wb_addr] == wb_tag);

  // Next busy vector: flush wipes everything; otherwise clear then set, so set wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_en) busy_d[wb_addr] = 1'b0;
      if (set_en) busy_d[iss_rd_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy bit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  // Producer tag capture on issue; flush leaves tags alone since busy bits gate their use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) tag_q[i] <= '0;
    end else if (set_en) begin
      tag_q[iss_rd_addr] <= iss_tag;
    end
  end

  // Saturating count of cycles where a valid instruction was held back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (iss_valid && !iss_ready && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, async reset mid-stall, then random traffic vs a reference model.
// A second instance with a 3-bit stall counter exercises saturation.
// Inputs driven 1 time unit after posedge, outputs sampled 2 units later.
module tb_reg_scoreboard;

  typedef struct {
    logic       v;
    logic       r1e;
    logic [4:0] r1;
    logic       r2e;
    logic [4:0] r2;
    logic       rde;
    logic [4:0] rd;
    logic [1:0] tg;
    logic       wbe;
    logic [4:0] wba;
    logic [1:0] wbt;
    logic       fl;
    logic       e_rdy;
    logic [31:0] e_busy;
    int         e_cnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        iss_valid, iss_r1_en, iss_r2_en, iss_rd_en, wb_en, flush;
  logic [4:0]  iss_r1_addr, iss_r2_addr, iss_rd_addr, wb_addr;
  logic [1:0]  iss_tag, wb_tag;
  logic        iss_ready, iss_ready_s;
  logic [31:0] busy_vec, busy_vec_s;
  logic [15:0] stall_cnt;
  logic [2:0]  stall_cnt_s;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit mb [32];
  int mt [32];
  int mcnt;

  vec_t vecs [18];

  reg_scoreboard dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_r1_en(iss_r1_en), .iss_r1_addr(iss_r1_addr),
    .iss_r2_en(iss_r2_en), .iss_r2_addr(iss_r2_addr),
    .iss_rd_en(iss_rd_en), .iss_rd_addr(iss_rd_addr), .iss_tag(iss_tag),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .flush(flush),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  reg_scoreboard #(.CNT_WIDTH(3)) dut_s (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready_s),
    .iss_r1_en(iss_r1_en), .iss_r1_addr(iss_r1_addr),
    .iss_r2_en(iss_r2_en), .iss_r2_addr(iss_r2_addr),
    .iss_rd_en(iss_rd_en), .iss_rd_addr(iss_rd_addr), .iss_tag(iss_tag),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .flush(flush),
    .busy_vec(busy_vec_s), .stall_cnt(stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic r1e, input logic [4:0] r1,
                              input logic r2e, input logic [4:0] r2,
                              input logic rde, input logic [4:0] rd, input logic [1:0] tg,
                              input logic wbe, input logic [4:0] wba, input logic [1:0] wbt,
                              input logic fl, input logic e_rdy, input logic [31:0] e_busy,
                              input int e_cnt);
    vec_t x;
    x.v = v; x.r1e = r1e; x.r1 = r1; x.r2e = r2e; x.r2 = r2;
    x.rde = rde; x.rd = rd; x.tg = tg; x.wbe = wbe; x.wba = wba; x.wbt = wbt;
    x.fl = fl; x.e_rdy = e_rdy; x.e_busy = e_busy; x.e_cnt = e_cnt;
    return x;
  endfunction

  task automatic apply(input vec_t x);
    iss_valid = x.v; iss_r1_en = x.r1e; iss_r1_addr = x.r1;
    iss_r2_en = x.r2e; iss_r2_addr = x.r2;
    iss_rd_en = x.rde; iss_rd_addr = x.rd; iss_tag = x.tg;
    wb_en = x.wbe; wb_addr = x.wba; wb_tag = x.wbt; flush = x.fl;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  // A source/destination conflicts if it names a nonzero register the model holds busy.
  function automatic bit m_conflict(input logic en, input logic [4:0] a);
    return en && (a != 5'd0) && mb[a];
  endfunction

  function automatic bit m_ready(input vec_t x);
    return !(m_conflict(x.r1e, x.r1) || m_conflict(x.r2e, x.r2) || m_conflict(x.rde, x.rd)) && !x.fl;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int i = 0; i < 32; i++) b[i] = mb[i];
    return b;
  endfunction

  function automatic int sat(input int c, input int lim);
    return (c > lim) ? lim : c;
  endfunction

  initial begin
    vec_t r;
    bit rdy, clr;

    //            v r1e r1 r2e r2 rde rd tg wbe wba wbt fl  rdy busy          cnt
    vecs[0]  = mk(1, 0, 0,  0, 0,  1, 5, 1, 0, 0, 0, 0,  1, 32'h0,        0);
    vecs[1]  = mk(1, 1, 5,  0, 0,  1, 6, 0, 0, 0, 0, 0,  0, 32'h20,       0);
    vecs[2]  = mk(1, 1, 5,  0, 0,  1, 6, 0, 1, 5, 1, 0,  0, 32'h20,       1);
    vecs[3]  = mk(1, 1, 5,  0, 0,  1, 6, 0, 0, 0, 0, 0,  1, 32'h0,        2);
    vecs[4]  = mk(1, 0, 0,  1, 6,  0, 0, 0, 1, 6, 2, 0,  0, 32'h40,       2);
    vecs[5]  = mk(1, 0, 0,  1, 6,  0, 0, 0, 0, 0, 0, 0,  0, 32'h40,       3);
    vecs[6]  = mk(0, 0, 0,  1, 6,  0, 0, 0, 1, 6, 0, 0,  0, 32'h40,       4);
    vecs[7]  = mk(1, 1, 0,  1, 0,  1, 0, 3, 0, 0, 0, 0,  1, 32'h0,        4);
    vecs[8]  = mk(1, 0, 0,  0, 0,  1, 7, 2, 0, 0, 0, 0,  1, 32'h0,        4);
    vecs[9]  = mk(1, 0, 0,  0, 0,  1, 7, 1, 0, 0, 0, 0,  0, 32'h80,       4);
    vecs[10] = mk(1, 0, 0,  0, 0,  1, 7, 1, 1, 7, 2, 0,  0, 32'h80,       5);
    vecs[11] = mk(1, 0, 0,  0, 0,  1, 7, 1, 0, 0, 0, 0,  1, 32'h0,        6);
    vecs[12] = mk(1, 0, 0,  0, 0,  1, 3, 0, 0, 0, 0, 0,  1, 32'h80,       6);
    vecs[13] = mk(1, 0, 0,  0, 0,  1, 9, 1, 1, 7, 1, 0,  1, 32'h88,       6);
    vecs[14] = mk(1, 0, 0,  0, 0,  1, 31,3, 0, 0, 0, 0,  1, 32'h208,      6);
    vecs[15] = mk(1, 0, 0,  0, 0,  1, 1, 0, 0, 0, 0, 1,  0, 32'h80000208, 6);
    vecs[16] = mk(1, 1, 31, 0, 0,  1, 2, 0, 0, 0, 0, 0,  1, 32'h0,        7);
    vecs[17] = mk(1, 1, 2,  0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 32'h4,        7);

    // Reset state
    rst = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("rst_busy", 64'(busy_vec), 64'h0);
    chk("rst_cnt", 64'(stall_cnt), 64'h0);
    chk("rst_ready", 64'(iss_ready), 64'h1);
    flush = 1'b1;
    #1;
    chk("rst_ready_flush", 64'(iss_ready), 64'h0);
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      apply(vecs[i]);
      #2;
      chk($sformatf("vec%0d_ready", i), 64'(iss_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_busy", i), 64'(busy_vec), 64'(vecs[i].e_busy));
      chk($sformatf("vec%0d_cnt", i), 64'(stall_cnt), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_cnt_sat", i), 64'(stall_cnt_s), 64'(sat(vecs[i].e_cnt, 7)));
      @(posedge clk);
      #1;
    end

    // Still stalled on r2, count keeps rising; then async reset mid-cycle
    apply(vecs[17]);
    #2;
    chk("pre_rst_cnt", 64'(stall_cnt), 64'd8);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_cnt", 64'(stall_cnt), 64'h0);
    chk("async_rst_busy", 64'(busy_vec), 64'h0);
    chk("async_rst_ready", 64'(iss_ready), 64'h1);
    @(negedge clk);
    rst = 1'b1;
    // Late writeback to the formerly busy register must not disturb anything
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("late_wb_busy", 64'(busy_vec), 64'h0);
    chk("late_wb_cnt", 64'(stall_cnt), 64'h0);
    @(posedge clk);
    #1;

    // Random traffic against the reference model
    for (int i = 0; i < 32; i++) begin
      mb[i] = 1'b0;
      mt[i] = 0;
    end
    mcnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r.v   = ($urandom_range(0, 3) != 0);
      r.r1e = 1'($urandom_range(0, 1));
      r.r1  = pick();
      r.r2e = 1'($urandom_range(0, 1));
      r.r2  = pick();
      r.rde = ($urandom_range(0, 3) != 0);
      r.rd  = pick();
      r.tg  = 2'($urandom_range(0, 3));
      r.wbe = 1'($urandom_range(0, 1));
      r.wba = pick();
      r.wbt = ($urandom_range(0, 3) != 0) ? 2'(mt[r.wba]) : 2'($urandom_range(0, 3));
      r.fl  = ($urandom_range(0, 19) == 0);
      apply(r);
      #2;
      rdy = m_ready(r);
      chk("rnd_ready", 64'(iss_ready), 64'(rdy));
      chk("rnd_busy", 64'(busy_vec), 64'(m_busy()));
      chk("rnd_cnt", 64'(stall_cnt), 64'(sat(mcnt, 65535)));
      chk("rnd_cnt_sat", 64'(stall_cnt_s), 64'(sat(mcnt, 7)));
      // Next state per the documented rules
      if (r.v && !rdy) mcnt++;
      if (r.fl) begin
        for (int k = 0; k < 32; k++) mb[k] = 1'b0;
      end else begin
        clr = r.wbe && (r.wba != 5'd0) && mb[r.wba] && (mt[r.wba] == int'(r.wbt));
        if (clr) mb[r.wba] = 1'b0;
        if (r.v && rdy && r.rde && (r.rd != 5'd0)) begin
          mb[r.rd] = 1'b1;
          mt[r.rd] = int'(r.tg);
        end
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
